// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, IF/ID register, stall/flush/redirect
// Optional IF_PERF_COUNT_EN adds fetch_count/bubble_count performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        exception,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
`ifdef IF_PERF_COUNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        normal_edge;
  logic        bubble_edge;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^redirect_target[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign bubble_edge = exception | redirect;
  assign normal_edge = ~bubble_edge & ~stall;

  // Exception beats redirect beats stall; a flush always leaves a bubble in IF/ID.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (exception) begin
      pc_d    = EXC_VECTOR;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (redirect) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = imem_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;

`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (normal_edge) fetch_count_d = fetch_count_q + 32'd1;
    if (bubble_edge) bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  logic unused_normal_edge;
  assign unused_normal_edge = normal_edge;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage (directed vectors, hand-computed expectations)
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redirect, exception;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_instr, pc;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  if_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .exception      (exception),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
`ifdef IF_PERF_COUNT_EN
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count),
`endif
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: two program words at 0/4, elsewhere 0x1000_0000 | addr.
  always_comb begin
    if (imem_addr == 32'h0000_0000)      imem_instr = 32'h2004_0003;
    else if (imem_addr == 32'h0000_0004) imem_instr = 32'h0C10_0005;
    else                                 imem_instr = 32'h1000_0000 | imem_addr;
  end

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: after every edge, compare DUT state against the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".pc"},        pc,             e.pc);
        check({e.name, ".imem_addr"}, imem_addr,      e.pc);
        check({e.name, ".instr"},     if_id_instr,    e.instr);
        check({e.name, ".pc_plus4"},  if_id_pc_plus4, e.pc4);
        check({e.name, ".valid"},     {31'd0, if_id_valid}, {31'd0, e.valid});
      end
    end
  end

  // Drive one edge's inputs at a falling edge and queue the state expected after the next rising edge.
  task automatic step(input string name, input logic st, input logic rd, input logic ex,
                      input logic [31:0] tgt, input logic [31:0] epc, input logic [31:0] einstr,
                      input logic [31:0] epc4, input logic ev);
    exp_t e;
    stall = st; redirect = rd; exception = ex; redirect_target = tgt;
    e.name = name; e.pc = epc; e.instr = einstr; e.pc4 = epc4; e.valid = ev;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    check({name, ".pc"},       pc,             32'h0);
    check({name, ".instr"},    if_id_instr,    32'h0);
    check({name, ".pc_plus4"}, if_id_pc_plus4, 32'h0);
    check({name, ".valid"},    {31'd0, if_id_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; exception = 1'b0; redirect_target = 32'h0;
    #2;
    check_reset_values("reset");
`ifdef IF_PERF_COUNT_EN
    check("reset.fetch_count",  fetch_count,  32'd0);
    check("reset.bubble_count", bubble_count, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    //    name        st  rd  ex  target         pc             instr          pc4            v
    step("fetch0",    0,  0,  0,  32'h0,         32'h0000_0004, 32'h2004_0003, 32'h0000_0004, 1);
    step("fetch1",    0,  0,  0,  32'h0,         32'h0000_0008, 32'h0C10_0005, 32'h0000_0008, 1);
    step("redir17",   0,  1,  0,  32'h0000_0017, 32'h0000_0014, 32'h0,         32'h0,         0);
    step("tgt14",     0,  0,  0,  32'h0,         32'h0000_0018, 32'h1000_0014, 32'h0000_0018, 1);
    step("seq18",     0,  0,  0,  32'h0,         32'h0000_001C, 32'h1000_0018, 32'h0000_001C, 1);
    step("seq1c",     0,  0,  0,  32'h0,         32'h0000_0020, 32'h1000_001C, 32'h0000_0020, 1);
    step("stall1",    1,  0,  0,  32'h0,         32'h0000_0020, 32'h1000_001C, 32'h0000_0020, 1);
    step("stall2",    1,  0,  0,  32'h0,         32'h0000_0020, 32'h1000_001C, 32'h0000_0020, 1);
    step("stall3",    1,  0,  0,  32'h0,         32'h0000_0020, 32'h1000_001C, 32'h0000_0020, 1);
    step("resume20",  0,  0,  0,  32'h0,         32'h0000_0024, 32'h1000_0020, 32'h0000_0024, 1);
    step("resume24",  0,  0,  0,  32'h0,         32'h0000_0028, 32'h1000_0024, 32'h0000_0028, 1);
    step("exc_all",   1,  1,  1,  32'h0000_0040, 32'h8000_0180, 32'h0,         32'h0,         0);
    step("exc_vec",   0,  0,  0,  32'h0,         32'h8000_0184, 32'h9000_0180, 32'h8000_0184, 1);
    step("loop1",     0,  1,  0,  32'h0000_0100, 32'h0000_0100, 32'h0,         32'h0,         0);
    step("loop2",     0,  1,  0,  32'h0000_0100, 32'h0000_0100, 32'h0,         32'h0,         0);
    step("loop_exit", 0,  0,  0,  32'h0,         32'h0000_0104, 32'h1000_0100, 32'h0000_0104, 1);
    step("redir_top", 0,  1,  0,  32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h0,         0);
    step("wrap",      0,  0,  0,  32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1);
    step("after_wrap",0,  0,  0,  32'h0,         32'h0000_0004, 32'h2004_0003, 32'h0000_0004, 1);

    // Asynchronous reset mid-cycle while stalled: outputs must clear before any clock edge.
    #3;
    stall = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("rst_f0",    0,  0,  0,  32'h0,         32'h0000_0004, 32'h2004_0003, 32'h0000_0004, 1);
    step("rst_f1",    0,  0,  0,  32'h0,         32'h0000_0008, 32'h0C10_0005, 32'h0000_0008, 1);
    step("rst_f2",    0,  0,  0,  32'h0,         32'h0000_000C, 32'h1000_0008, 32'h0000_000C, 1);
    step("rst_f3",    0,  0,  0,  32'h0,         32'h0000_0010, 32'h1000_000C, 32'h0000_0010, 1);
    step("rst_f4",    0,  0,  0,  32'h0,         32'h0000_0014, 32'h1000_0010, 32'h0000_0014, 1);
    step("rst_st1",   1,  0,  0,  32'h0,         32'h0000_0014, 32'h1000_0010, 32'h0000_0014, 1);
    step("rst_st2",   1,  0,  0,  32'h0,         32'h0000_0014, 32'h1000_0010, 32'h0000_0014, 1);
    step("rst_rd",    0,  1,  0,  32'h0000_0200, 32'h0000_0200, 32'h0,         32'h0,         0);
    stall = 1'b1; redirect = 1'b0;
`ifdef IF_PERF_COUNT_EN
    check("perf.fetch_count",  fetch_count,  32'd5);
    check("perf.bubble_count", bubble_count, 32'd1);
`endif
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
